// File: rtl/dmem_slot_arbiter.sv
// dmem_slot_arbiter: sequences both VLIW load/store slots onto one byte-wide data memory port, slot0 first.
// Optional same-address combining of the two slots is enabled by defining DMEM_FWD_EN.
module dmem_slot_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              done,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_hit,
    output logic              err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S0   = 2'd1;
    localparam logic [1:0] S1   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        r_state, w_next;
    logic              r_req0, r_we0, r_req1, r_we1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic [DATA_W-1:0] r_wdata0, r_wdata1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              w_s0, w_s1, w_busy, w_timeout, w_adv, w_fuse;
    logic [DATA_W-1:0] w_rval;

    assign w_s0      = (r_state == S0);
    assign w_s1      = (r_state == S1);
    assign w_busy    = w_s0 | w_s1;
    assign w_timeout = w_busy & ~mem_hit & (r_cnt == CNT_W'(MAX_WAIT - 1));
    assign w_adv     = w_busy & (mem_hit | w_timeout);
    // An aborted access returns zero to the load that issued it.
    assign w_rval    = mem_hit ? mem_rdata : '0;

`ifdef DMEM_FWD_EN
    // Same-address pair served by one access in S0, except load0/store1 which must see the old data.
    assign w_fuse = r_req0 & r_req1 & (r_addr0 == r_addr1) & ~(~r_we0 & r_we1);
`else
    assign w_fuse = 1'b0;
`endif

    assign stall     = w_busy | ((r_state == IDLE) & (req0 | req1));
    assign done      = (r_state == DONE);
    assign mem_req   = w_busy;
    assign mem_we    = (w_s0 & r_we0) | (w_s1 & r_we1);
    assign mem_addr  = w_s0 ? r_addr0 : w_s1 ? r_addr1 : '0;
    assign mem_wdata = w_s0 ? ((w_fuse & r_we1) ? r_wdata1 : r_wdata0) : w_s1 ? r_wdata1 : '0;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign err       = r_err;

    // Next-state selection: slot0 access, then slot1 access, then one done cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (req0 | req1) ? (req0 ? S0 : S1) : IDLE;
            S0:      w_next = w_adv ? ((r_req1 & ~w_fuse) ? S1 : DONE) : S0;
            S1:      w_next = w_adv ? DONE : S1;
            default: w_next = IDLE;
        endcase
    end

    // State register and per-access wait counter, which restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_busy && w_next == r_state) ? r_cnt + 1'b1 : '0;
        end
    end

    // Capture the whole bundle when it first presents in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req0   <= 1'b0;
            r_we0    <= 1'b0;
            r_addr0  <= '0;
            r_wdata0 <= '0;
            r_req1   <= 1'b0;
            r_we1    <= 1'b0;
            r_addr1  <= '0;
            r_wdata1 <= '0;
        end else if (r_state == IDLE && (req0 | req1)) begin
            r_req0   <= req0;
            r_we0    <= we0;
            r_addr0  <= addr0;
            r_wdata0 <= wdata0;
            r_req1   <= req1;
            r_we1    <= we1;
            r_addr1  <= addr1;
            r_wdata1 <= wdata1;
        end
    end

    // Load results; stores and idle slots leave their result register untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_s0 && w_adv) begin
            if (!r_we0)
                r_rdata0 <= w_rval;
            if (w_fuse && !r_we1)
                r_rdata1 <= r_we0 ? r_wdata0 : w_rval;
        end else if (w_s1 && w_adv && !r_we1) begin
            r_rdata1 <= w_rval;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_timeout)
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_dmem_slot_arbiter.sv
// tb_dmem_slot_arbiter: directed bundles against a byte memory model with programmable hit delay.
module tb_dmem_slot_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  rdata0, rdata1;
    logic        done, stall, mem_req, mem_we, mem_hit, err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int          checks = 0;
    int          failures = 0;
    int          nstall, done_cyc, nacc, hit_lo;
    logic        we_seen;
    logic [31:0] acc_addr [0:3];
    logic        acc_we [0:3];
    logic [7:0]  mem [0:255];

    dmem_slot_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .done(done), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_hit(mem_hit), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic run(input logic r0, input logic w0, input logic [31:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [7:0] d1);
        nstall = 0;
        done_cyc = 0;
        nacc = 0;
        we_seen = 1'b0;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            mem_hit = (cyc > hit_lo);
            #1;
            if (stall) nstall++;
            if (mem_we) we_seen = 1'b1;
            if (mem_req && mem_hit) begin
                if (nacc < 4) begin
                    acc_addr[nacc] = mem_addr;
                    acc_we[nacc] = mem_we;
                end
                nacc++;
                if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
            end
            if (done) done_cyc = cyc;
            @(posedge clk);
            #1;
            req0 = 1'b0;
            req1 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done_cyc == 0) begin
            failures++;
            $display("FAIL bundle_timeout got no done within 60 cycles, required done pulse");
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({rdata0, rdata1, done, stall, mem_req, mem_we, mem_addr, mem_wdata, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got r0=%h r1=%h done=%b stall=%b req=%b we=%b addr=%h wd=%h err=%b, required all 0",
                     rdata0, rdata1, done, stall, mem_req, mem_we, mem_addr, mem_wdata, err);
        end
    endtask

    task automatic test_single_load();
        hit_lo = 0;
        run(1, 0, 32'h4, 8'h00, 0, 0, 32'h0, 8'h00);
        checks++; if (nstall !== 2) begin failures++; $display("FAIL single_stall got %0d required 2", nstall); end
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL single_done got %0d required 3", done_cyc); end
        checks++; if (rdata0 !== 8'h5A) begin failures++; $display("FAIL single_rdata0 got %h required 5a", rdata0); end
        checks++; if (we_seen !== 1'b0) begin failures++; $display("FAIL single_we got %b required 0", we_seen); end
    endtask

    task automatic test_store_load();
        run(1, 1, 32'h2, 8'h11, 1, 0, 32'h3, 8'h00);
        checks++; if (nacc !== 2) begin failures++; $display("FAIL sl_naccess got %0d required 2", nacc); end
        checks++; if ({acc_addr[0], acc_addr[1]} !== {32'h2, 32'h3}) begin failures++; $display("FAIL sl_addr_seq got %h,%h required 2,3", acc_addr[0], acc_addr[1]); end
        checks++; if ({acc_we[0], acc_we[1]} !== 2'b10) begin failures++; $display("FAIL sl_we_seq got %b%b required 10", acc_we[0], acc_we[1]); end
        checks++; if (done_cyc !== 4) begin failures++; $display("FAIL sl_done got %0d required 4", done_cyc); end
        checks++; if (nstall !== 3) begin failures++; $display("FAIL sl_stall got %0d required 3", nstall); end
        checks++; if (rdata1 !== 8'h77) begin failures++; $display("FAIL sl_rdata1 got %h required 77", rdata1); end
        checks++; if (rdata0 !== 8'h5A) begin failures++; $display("FAIL sl_rdata0_kept got %h required 5a", rdata0); end
        checks++; if (mem[2] !== 8'h11) begin failures++; $display("FAIL sl_mem_write got %h required 11", mem[2]); end
    endtask

    task automatic test_same_addr();
        int exp_done, exp_acc;
`ifdef DMEM_FWD_EN
        exp_done = 3; exp_acc = 1;
`else
        exp_done = 4; exp_acc = 2;
`endif
        run(1, 1, 32'h6, 8'h33, 1, 0, 32'h6, 8'h00);
        checks++; if (rdata1 !== 8'h33) begin failures++; $display("FAIL fwd_rdata1 got %h required 33", rdata1); end
        checks++; if (done_cyc !== exp_done) begin failures++; $display("FAIL fwd_done got %0d required %0d", done_cyc, exp_done); end
        checks++; if (nacc !== exp_acc) begin failures++; $display("FAIL fwd_naccess got %0d required %0d", nacc, exp_acc); end
        run(1, 1, 32'h20, 8'hA1, 1, 1, 32'h20, 8'hB2);
        checks++; if (mem[8'h20] !== 8'hB2) begin failures++; $display("FAIL ss_mem got %h required b2", mem[8'h20]); end
        checks++; if (nacc !== exp_acc) begin failures++; $display("FAIL ss_naccess got %0d required %0d", nacc, exp_acc); end
    endtask

    task automatic test_hit_delay();
        hit_lo = 4;
        run(1, 0, 32'h8, 8'h00, 0, 0, 32'h0, 8'h00);
        checks++; if (nstall !== 5) begin failures++; $display("FAIL delay_stall got %0d required 5", nstall); end
        checks++; if (done_cyc !== 6) begin failures++; $display("FAIL delay_done got %0d required 6", done_cyc); end
        checks++; if (rdata0 !== 8'hC3) begin failures++; $display("FAIL delay_rdata0 got %h required c3", rdata0); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL delay_err got %b required 0", err); end
        checks++; if (rdata1 !== 8'h33) begin failures++; $display("FAIL delay_rdata1_kept got %h required 33", rdata1); end
    endtask

    task automatic test_timeout();
        hit_lo = 1000;
        run(1, 0, 32'h8, 8'h00, 1, 0, 32'h9, 8'h00);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got %b required 1", err); end
        checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL to_rdata0 got %h required 00", rdata0); end
        checks++; if (rdata1 !== 8'h00) begin failures++; $display("FAIL to_rdata1 got %h required 00", rdata1); end
        checks++; if (done_cyc !== 34) begin failures++; $display("FAIL to_done got %0d required 34", done_cyc); end
        checks++; if (nstall !== 33) begin failures++; $display("FAIL to_stall got %0d required 33", nstall); end
        hit_lo = 0;
        run(0, 0, 32'h0, 8'h00, 1, 0, 32'h9, 8'h00);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL sticky_err got %b required 1", err); end
        checks++; if (rdata1 !== 8'h44) begin failures++; $display("FAIL sticky_rdata1 got %h required 44", rdata1); end
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL sticky_done got %0d required 3", done_cyc); end
    endtask

    task automatic test_reset_mid();
        logic done_seen;
        done_seen = 1'b0;
        mem_hit = 1'b1;
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h10; wdata0 = 8'h00;
        req1 = 1; we1 = 1; addr1 = 32'h11; wdata1 = 8'h99;
        @(posedge clk);
        #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h11}) begin failures++; $display("FAIL rm_s1_store got req=%b we=%b addr=%h required 1 1 11", mem_req, mem_we, mem_addr); end
        reset = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we, stall, done, err} !== 5'b0) begin failures++; $display("FAIL rm_ctrl got req=%b we=%b stall=%b done=%b err=%b required 0", mem_req, mem_we, stall, done, err); end
        checks++; if ({rdata0, rdata1, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL rm_data got r0=%h r1=%h addr=%h wd=%h required 0", rdata0, rdata1, mem_addr, mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || mem_req) done_seen = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (done || mem_req) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL rm_no_done got activity=%b required 0", done_seen); end
        checks++; if (mem[8'h11] !== 8'hEE) begin failures++; $display("FAIL rm_store_abandoned got %h required ee", mem[8'h11]); end
        run(0, 0, 32'h0, 8'h00, 1, 0, 32'h9, 8'h00);
        checks++; if (rdata1 !== 8'h44) begin failures++; $display("FAIL rm_after_rdata1 got %h required 44", rdata1); end
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL rm_after_done got %0d required 3", done_cyc); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_after_err got %b required 0", err); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h03] = 8'h77;
        mem[8'h04] = 8'h5A;
        mem[8'h08] = 8'hC3;
        mem[8'h09] = 8'h44;
        mem[8'h11] = 8'hEE;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_hit = 1'b1;
        hit_lo = 0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_single_load();
        test_store_load();
        test_same_addr();
        test_hit_delay();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_slot_arbiter.md
Name: dmem_slot_arbiter

Overview:
- Sequences the single byte-wide data memory port between the two load/store slots of a VLIW bundle.
- Latches both slot requests, issues them to data memory in program order (slot0 then slot1), and waits on the memory hit.
- Stalls the pipeline until the whole bundle's memory work completes, then returns read data per slot.
- Sits between the execute-stage slot units and the data memory (which has a hit output).

Parameters:
ADDR_W, 32, address width
DATA_W, 8, data width of memory port
MAX_WAIT, 16, cycles allowed per access without hit before abort
CNT_W, 5, width of wait counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock, posedge active
reset  in  1  asynchronous active-high reset
req0  in  1  slot0 has memory op this bundle
we0  in  1  slot0 op is store (1) / load (0)
addr0  in  ADDR_W  slot0 address
wdata0  in  DATA_W  slot0 store data
req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  same for slot1
rdata0  out  DATA_W  slot0 load result
rdata1  out  DATA_W  slot1 load result
done  out  1  one-cycle pulse: bundle memory work complete, rdata valid
stall  out  1  hold pipeline
mem_req  out  1  access active to data memory
mem_we  out  1  write enable to data memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_hit  in  1  memory access complete this cycle
err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state=IDLE; rdata0/1=0, done=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, wait counter=0, latched request regs=0.
- States: IDLE, S0, S1, DONE.
- IDLE: mem_* all 0. If req0|req1 at posedge, latch req/we/addr/wdata for both slots; next = S0 if req0 else S1. No req: stay.
- stall = (state in S0,S1) | (state==IDLE & (req0|req1)); combinational, so stall rises in the same cycle the bundle presents. stall=0 in DONE.
- S0: mem_req=1, mem_addr=addr0_q, mem_we=we0_q, mem_wdata=wdata0_q.
  - Posedge with mem_hit=1: if load, rdata0 <= mem_rdata. Next = S1 if req1_q else DONE.
- S1: same as S0, using slot1 latched fields and rdata1; next = DONE on hit.
- Wait counter:
  - Cleared on entry to S0/S1; increments each cycle in S0/S1 with mem_hit=0.
  - When counter == MAX_WAIT-1 and mem_hit=0: abort access; err <= 1; the slot's rdata <= 0 if load; advance as if hit.
  - err clears only on reset.
- DONE: done=1 for exactly one cycle; next = IDLE. Requests present in DONE are ignored (pipeline advances at end of DONE).
- rdata0/1 hold their value until overwritten by a later load of that slot; a slot not requesting or storing leaves its rdata unchanged.
- Latency with mem_hit always 1:
  - Single op: stall high 2 cycles (IDLE, S0/S1), done on cycle 3.
  - Two ops: stall high 3 cycles, done on cycle 4.
- Ordering: slot0 always before slot1. Same-address store/store leaves wdata1; store0/load1 returns wdata0.
- Reset mid-access: mem_we/mem_req drop immediately; the pending store is abandoned; no done pulse.

Optional Feature:
- Macro: DMEM_FWD_EN.
- Defined: when both slots request and addr0_q==addr1_q, the memory is accessed once in S0 and S1 is skipped (S0 -> DONE):
  - store0/load1: rdata1 <= wdata0_q.
  - load0/load1: rdata1 <= mem_rdata with rdata0.
  - load0/store1: not combined; S1 is issued normally.
  - store0/store1: only store1 data is written in S0.
- Undefined: always two sequential accesses as above.

Test Plan:
- Hit tied 1; req0 load addr 0x4 (mem holds 0x5A), req1=0 -> stall high 2 cycles, done on cycle 3, rdata0=0x5A, mem_we never 1.
- Hit tied 1; slot0 store 0x11 @0x2, slot1 load @0x3 (holds 0x77) -> mem_addr sequence 0x2 then 0x3, mem_we 1 then 0, done on cycle 4, rdata1=0x77.
- Slot0 store 0x33 @0x6, slot1 load @0x6:
  - Without DMEM_FWD_EN: two accesses, rdata1=0x33, done cycle 4.
  - With DMEM_FWD_EN: one access, rdata1=0x33, done cycle 3.
- mem_hit low 3 cycles then high on slot0 load -> stall extends 3 cycles, err stays 0, correct rdata0.
- mem_hit held 0, MAX_WAIT=16 -> after 16 cycles in S0 err=1, rdata0=0, proceeds to S1/DONE; err stays 1 through later bundles until reset.
- Assert reset during S1 of a store -> mem_we/mem_req 0 immediately, all outputs at reset values, no done pulse; next bundle after reset completes normally.
